// File: rtl/sm_to_tc_serial.sv
// sm_to_tc_serial: bit-serial sign-magnitude to two's-complement converter.
//
// Walks the magnitude LSB-first, one bit per clock. Bits are copied up to and
// including the first 1. When the operand is negative, every later bit is
// inverted. The result is held until the next conversion completes.
//
// Ports:
//   CLK    - system clock, rising edge
//   RST    - synchronous active-high reset, highest priority
//   Start  - request a conversion, sampled only while Ready=1
//   Sign   - operand sign (1 = negative), sampled with Start
//   Mag    - unsigned magnitude, sampled with Start
//   Ready  - idle, a conversion can be accepted
//   Busy   - bits are being shifted
//   Done   - one-cycle pulse, Result/Ovf updated in the same cycle
//   Result - two's-complement result, held until the next Done
//   Ovf    - value not representable in WIDTH-bit signed form
module sm_to_tc_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] Mag,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Ovf
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_seen;
    logic             r_sign;
    logic             r_ovf_int;

    logic             w_bit;
    logic             w_out;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_next;

    assign w_bit      = r_shift[0];
    // Invert only once a 1 has already passed through (two's-complement negate).
    assign w_out      = w_bit ^ (r_sign & r_seen);
    assign w_acc_next = {w_out, r_acc[WIDTH-1:1]};

    // Positive: MSB set does not fit. Negative: anything above 2^(N-1) does not
    // fit, so 100..0 itself (the most-negative value) is still representable.
    assign w_ovf = Sign ? (Mag[WIDTH-1] & (|Mag[WIDTH-2:0])) : Mag[WIDTH-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_sign    <= 1'b0;
            r_ovf_int <= 1'b0;
            Ready     <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Result    <= '0;
            Ovf       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    Done <= 1'b0;
                    if (Start) begin
                        r_shift   <= Mag;
                        r_sign    <= Sign;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_seen    <= 1'b0;
                        r_ovf_int <= w_ovf;
                        Ready     <= 1'b0;
                        Busy      <= 1'b1;
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    r_shift <= r_shift >> 1;
                    r_seen  <= r_seen | w_bit;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // Last bit: publish the completed accumulator directly.
                        Result  <= w_acc_next;
                        Ovf     <= r_ovf_int;
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    Done    <= 1'b0;
                    Ready   <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    Ready   <= 1'b1;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_to_tc_serial.sv
// Scoreboard bench for sm_to_tc_serial: a WIDTH=4 and a WIDTH=8 instance.
// Drivers push expected responses (from an integer negate/wrap model) when a
// conversion is accepted; per-instance monitors pop and compare on Done.
module tb_sm_to_tc_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       rst, start, sign;
    logic [3:0] mag;
    logic       ready, busy, done, ovf;
    logic [3:0] result;

    // WIDTH=8 instance
    logic       rst8, start8, sign8;
    logic [7:0] mag8;
    logic       ready8, busy8, done8, ovf8;
    logic [7:0] result8;

    sm_to_tc_serial #(.WIDTH(4)) u_dut4 (
        .CLK(clk), .RST(rst), .Start(start), .Sign(sign), .Mag(mag),
        .Ready(ready), .Busy(busy), .Done(done), .Result(result), .Ovf(ovf)
    );

    sm_to_tc_serial #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst8), .Start(start8), .Sign(sign8), .Mag(mag8),
        .Ready(ready8), .Busy(busy8), .Done(done8), .Result(result8), .Ovf(ovf8)
    );

    typedef struct packed {
        int         acc;
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   chk_en = 0;
    bit   chk8_en = 0;
    bit   fin8 = 0;
    logic [3:0] held4_res = '0;
    logic       held4_ovf = 1'b0;
    logic [7:0] held8_res = '0;
    logic       held8_ovf = 1'b0;
    int   last_acc4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed value = +/-Mag, result wraps modulo 2^w,
    // overflow when the signed value lies outside [-2^(w-1), 2^(w-1)-1].
    function automatic logic [8:0] ref_conv(input int w, input bit s, input logic [7:0] m);
        int v;
        int lim;
        logic [8:0] r;
        v    = s ? -int'(m) : int'(m);
        lim  = 1 << (w - 1);
        r[7:0] = 8'(v & ((1 << w) - 1));
        r[8]   = (v > lim - 1) || (v < -lim);
        return r;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        int   d;
        bit   e_done;
        bit   e_busy;
        exp_t e;
        if (chk_en) begin
            e_done = 0;
            e_busy = 0;
            if (q4.size() > 0) begin
                d = cyc - q4[0].acc;
                e_done = (d == 4);
                e_busy = (d >= 0 && d < 4);
                if (d > 4) begin
                    check("done4_late", d, 4);
                    void'(q4.pop_front());
                end
            end
            check("ready4", ready, q4.size() == 0);
            check("busy4", busy, e_busy);
            check("done4", done, e_done);
            if (e_done) begin
                e = q4.pop_front();
                check("result4", result, e.res[3:0]);
                check("ovf4", ovf, e.ovf);
                held4_res = e.res[3:0];
                held4_ovf = e.ovf;
            end else begin
                check("hold_result4", result, held4_res);
                check("hold_ovf4", ovf, held4_ovf);
            end
        end
    end

    always @(negedge clk) begin
        int   d;
        bit   e_done;
        bit   e_busy;
        exp_t e;
        if (chk8_en) begin
            e_done = 0;
            e_busy = 0;
            if (q8.size() > 0) begin
                d = cyc - q8[0].acc;
                e_done = (d == 8);
                e_busy = (d >= 0 && d < 8);
                if (d > 8) begin
                    check("done8_late", d, 8);
                    void'(q8.pop_front());
                end
            end
            check("ready8", ready8, q8.size() == 0);
            check("busy8", busy8, e_busy);
            check("done8", done8, e_done);
            if (e_done) begin
                e = q8.pop_front();
                check("result8", result8, e.res);
                check("ovf8", ovf8, e.ovf);
                held8_res = e.res;
                held8_ovf = e.ovf;
            end else begin
                check("hold_result8", result8, held8_res);
                check("hold_ovf8", ovf8, held8_ovf);
            end
        end
    end

    // ---------------- WIDTH=4 driver ----------------
    task automatic drive4(input bit st, input bit s, input logic [3:0] m, input bit r,
                          output bit acc);
        exp_t e;
        @(negedge clk);
        #1;
        start = st;
        sign  = s;
        mag   = m;
        rst   = r;
        acc   = 0;
        if (r) begin
            q4.delete();
            held4_res = '0;
            held4_ovf = 1'b0;
        end else if (st && ready) begin
            e.acc = cyc + 1;
            {e.ovf, e.res} = ref_conv(4, s, {4'b0, m});
            q4.push_back(e);
            last_acc4 = e.acc;
            acc = 1;
        end
    endtask

    task automatic issue4(input bit s, input logic [3:0] m);
        bit a;
        a = 0;
        for (int i = 0; i < 40 && !a; i++) drive4(1, s, m, 0, a);
        if (!a) check("issue4_timeout", {31'b0, a}, 1);
    endtask

    task automatic drain4();
        bit a;
        for (int i = 0; i < 40 && q4.size() > 0; i++) drive4(0, 0, 4'h0, 0, a);
        if (q4.size() > 0) check("drain4_timeout", q4.size(), 0);
        drive4(0, 0, 4'h0, 0, a);
    endtask

    // ---------------- WIDTH=8 driver ----------------
    task automatic drive8(input bit st, input bit s, input logic [7:0] m, input bit r,
                          output bit acc);
        exp_t e;
        @(negedge clk);
        #1;
        start8 = st;
        sign8  = s;
        mag8   = m;
        rst8   = r;
        acc    = 0;
        if (r) begin
            q8.delete();
            held8_res = '0;
            held8_ovf = 1'b0;
        end else if (st && ready8) begin
            e.acc = cyc + 1;
            {e.ovf, e.res} = ref_conv(8, s, m);
            q8.push_back(e);
            acc = 1;
        end
    endtask

    task automatic issue8(input bit s, input logic [7:0] m);
        bit a;
        a = 0;
        for (int i = 0; i < 60 && !a; i++) drive8(1, s, m, 0, a);
        if (!a) check("issue8_timeout", {31'b0, a}, 1);
        drive8(0, 0, 8'h00, 0, a);
    endtask

    initial begin
        bit a;
        start8 = 0; sign8 = 0; mag8 = '0; rst8 = 1;
        repeat (3) drive8(0, 0, 8'h00, 1, a);
        chk8_en = 1;
        issue8(1, 8'h80);
        issue8(1, 8'h01);
        issue8(0, 8'h7F);
        issue8(0, 8'h80);
        issue8(1, 8'h81);
        issue8(1, 8'h00);
        for (int i = 0; i < 12; i++) issue8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 40 && q8.size() > 0; i++) drive8(0, 0, 8'h00, 0, a);
        if (q8.size() > 0) check("drain8_timeout", q8.size(), 0);
        drive8(0, 0, 8'h00, 0, a);
        fin8 = 1;
    end

    // ---------------- main sequence ----------------
    initial begin
        bit a;
        int a1;
        start = 0; sign = 0; mag = '0; rst = 1;
        repeat (3) drive4(0, 0, 4'h0, 1, a);
        chk_en = 1;
        drive4(0, 0, 4'h0, 0, a);

        // First conversion and ABS round-trip vectors
        issue4(1, 4'b0001); drain4();
        issue4(1, 4'b0010); drain4();
        issue4(1, 4'b0110); drain4();
        issue4(1, 4'b0111); drain4();
        issue4(0, 4'b0101); drain4();

        // Representability boundaries
        issue4(1, 4'b1000); drain4();
        issue4(0, 4'b1000); drain4();
        issue4(1, 4'b1001); drain4();
        issue4(1, 4'b0000); drain4();

        // Start during SHIFT is ignored
        issue4(1, 4'b0100);
        drive4(0, 0, 4'h0, 0, a);
        drive4(1, 0, 4'b0011, 0, a);
        drive4(0, 0, 4'h0, 0, a);
        drain4();

        // Start held high: next accept exactly WIDTH+2 cycles later
        issue4(1, 4'b0010);
        a1 = last_acc4;
        issue4(0, 4'b0011);
        check("throughput4", last_acc4 - a1, 6);
        drain4();

        // Reset during the 2nd SHIFT cycle aborts, then a clean conversion
        issue4(0, 4'b0111);
        drive4(0, 0, 4'h0, 0, a);
        drive4(0, 0, 4'h0, 1, a);
        drive4(0, 0, 4'h0, 0, a);
        issue4(1, 4'b0101); drain4();

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            drive4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), $urandom_range(0, 63) == 0, a);
        end
        drain4();

        for (int i = 0; i < 2000 && !fin8; i++) @(negedge clk);
        if (!fin8) check("w8_timeout", {31'b0, fin8}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
